hub75_scanner: RTL and testbench
================================

Name: hub75_scanner

Overview:
- Read-side consumer of the double-buffered frame RAM (sync_pdp_ram).
- Walks the front buffer row by row and bit plane by bit plane, fetching top and bottom half pixels through the RAM read port.
- Shifts the pixels out on the HUB75 panel pins and drives latch, output enable and row address with binary-coded modulation.
- Owns the buffer_toggle swap at frame boundaries, via a request/ack handshake with the writer side.

Parameters:
- COLUMNS, 64: pixels per panel row; read column index is 6 bits.
- ROW_BITS, 4: row-pair address width; 16 row pairs.
- PLANES, 8: bit planes per colour channel.
- ON_TIME, 2: display cycles for plane 0; plane p shows for ON_TIME << p cycles.

Ports:
- clk  in  1: single clock, also drives the RAM read_clk.
- reset_n  in  1: asynchronous, active-low reset.
- enable  in  1: run scanning; sampled only in IDLE.
- swap_req  in  1: writer has completed the back buffer.
- swap_ack  out  1: one-cycle pulse when buffer_toggle flips.
- buffer_toggle  out  1: RAM bank select.
- frame_done  out  1: one-cycle pulse at the end of each frame.
- read_addr  out  10: {row[3:0], col[5:0]}.
- read_en  out  1: RAM read enable.
- read_data_top  in  32: 0x00RRGGBB; valid the cycle after read_en.
- read_data_bottom  in  32: same format, for row + 16.
- hub75_r1 / g1 / b1  out  1 each: top-half colour bits.
- hub75_r2 / g2 / b2  out  1 each: bottom-half colour bits.
- hub75_clk  out  1: panel shift clock.
- hub75_lat  out  1: panel latch.
- hub75_oe_n  out  1: panel output enable, active low.
- hub75_addr  out  4: panel row address.

Behaviour:
- Reset values: all outputs 0, except hub75_oe_n = 1. State = IDLE; row = plane = col = 0.
- Colour bit extraction for plane p: R = data[16+p], G = data[8+p], B = data[p]. top feeds *1, bottom feeds *2. Registered outputs.
- IDLE:
  - oe_n = 1.
  - If swap_req = 1: flip buffer_toggle and pulse swap_ack in the same cycle.
  - If enable = 1: go to PREFETCH.
- PREFETCH, 2 cycles:
  - Cycle 0: read_addr = {row, 0}, read_en = 1.
  - Cycle 1: RAM data valid; colour regs capture it at the end of the cycle.
  - Then SHIFT col 0, phase 0.
- SHIFT, 2 cycles per column:
  - Phase 0: hub75_clk = 0. If col < COLUMNS-1, issue read {row, col+1}.
  - Phase 1: hub75_clk = 1. Colour regs capture the col+1 data at the end of the cycle.
  - After col 63 phase 1: go to BLANK.
  - Shift duration: 2 × COLUMNS = 128 cycles. Colour outputs are stable across each hub75_clk rising edge.
- BLANK, 1 cycle: oe_n = 1, hub75_clk = 0.
- LATCH, 1 cycle: hub75_lat = 1, hub75_addr <= row.
- DISPLAY: oe_n = 0 for exactly ON_TIME << plane cycles, counted by a 16-bit down-counter. Then:
  - If plane < PLANES-1: plane++ and go to PREFETCH (same row).
  - Otherwise: plane = 0. If row < 15: row++ and go to PREFETCH.
  - Otherwise: row = 0, pulse frame_done, go to IDLE.
- Frame boundary: the swap check and enable check happen in IDLE only.
  - A swap_req arriving mid-frame is held (level signal) until IDLE. No tearing.
  - enable deasserted mid-frame: the current frame completes, then the block waits in IDLE.
- Simultaneous swap_req and enable in IDLE: the toggle occurs, and PREFETCH of the new bank starts next cycle.
- Wrap-around: col, row and plane counters wrap only via the explicit transitions above. read_addr never exceeds 1023.
- Async reset mid-frame: immediate return to reset values. oe_n goes high without waiting for a clock.
- read_en is low outside PREFETCH cycle 0 and SHIFT phase 0 reads.

Decomposition:
- Package hub75_pkg:
  - Scanner state enum: IDLE, PREFETCH, SHIFT, BLANK, LATCH, DISPLAY.
  - Pixel field offsets: RED = 16, GREEN = 8, BLUE = 0.
  - COLUMNS / ROW_BITS defaults.
- Sub-module hub75_bcm_timer: loadable down-counter. Inputs plane and ON_TIME; outputs done. Instantiated once for DISPLAY.

Test Plan:
- Reset: hold reset_n = 0 → oe_n = 1, all else 0. Release with enable = 0 → stays IDLE, read_en never asserts.
- First row, plane 0 (RAM model with 1-cycle latency; top pixel c = 0x000001 when c odd, bottom = 0x010000 when c odd):
  - enable = 1 → 128 hub75_clk edges: 64 rising edges, as the rising edge of each 2-cycle clk-low/clk-high pair.
  - b1 = 1 and r2 = 1 on odd columns.
  - lat pulse with hub75_addr = 0; oe_n low for exactly 2 cycles.
- BCM timing: count oe_n-low cycles per plane for row 0 → 2, 4, 8, …, 256. Then hub75_addr = 1 on the next latch.
- Full frame: frame_done pulses once after 16 × 8 latches. Total read_en count = 16 × 8 × 64 = 8192. Last address 0x3FF.
- Swap handshake: assert swap_req at row 5 → no toggle until after frame_done. Then in IDLE: buffer_toggle flips 0→1 and swap_ack pulses 1 cycle.
- Reset mid-SHIFT at col 30 → oe_n = 1 and lat = 0 asynchronously. After release, row = 0 and plane = 0, and the first read is address 0.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 panel scanner.
// Pixel words are 0x00RRGGBB; each channel's bit planes sit at the offsets below.
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREFETCH,
    SHIFT,
    BLANK,
    LATCH,
    DISPLAY
  } scan_state_t;

  localparam int RED   = 16;
  localparam int GREEN = 8;
  localparam int BLUE  = 0;

  localparam int DEF_COLUMNS  = 64;
  localparam int DEF_ROW_BITS = 4;
  localparam int DEF_PLANES   = 8;
  localparam int DEF_ON_TIME  = 2;
  localparam int TIMER_BITS   = 16;

endpackage

// File: rtl/hub75_bcm_timer.sv
// Binary-coded-modulation on-time counter: loads (ON_TIME << plane) - 1 and
// counts down to zero, so done rises after exactly ON_TIME << plane cycles.
module hub75_bcm_timer
  import hub75_pkg::*;
#(
  parameter int ON_TIME    = DEF_ON_TIME,
  parameter int PLANE_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [PLANE_BITS-1:0] plane,
  output logic                  done
);

  logic [TIMER_BITS-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= (TIMER_BITS'(ON_TIME) << plane) - TIMER_BITS'(1);
    end else if (count_reg != '0) begin
      count_reg <= count_reg - TIMER_BITS'(1);
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/hub75_scanner.sv
// HUB75 scanner: walks the front frame buffer row by row and plane by plane,
// shifts pixels to the panel and drives latch/OE/address with BCM timing.
module hub75_scanner
  import hub75_pkg::*;
#(
  parameter int COLUMNS  = DEF_COLUMNS,
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int PLANES   = DEF_PLANES,
  parameter int ON_TIME  = DEF_ON_TIME
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  enable,
  input  logic                                  swap_req,
  output logic                                  swap_ack,
  output logic                                  buffer_toggle,
  output logic                                  frame_done,
  output logic [ROW_BITS+$clog2(COLUMNS)-1:0]   read_addr,
  output logic                                  read_en,
  input  logic [31:0]                           read_data_top,
  input  logic [31:0]                           read_data_bottom,
  output logic                                  hub75_r1,
  output logic                                  hub75_g1,
  output logic                                  hub75_b1,
  output logic                                  hub75_r2,
  output logic                                  hub75_g2,
  output logic                                  hub75_b2,
  output logic                                  hub75_clk,
  output logic                                  hub75_lat,
  output logic                                  hub75_oe_n,
  output logic [ROW_BITS-1:0]                   hub75_addr
);

  localparam int COL_BITS   = $clog2(COLUMNS);
  localparam int PLANE_BITS = $clog2(PLANES);
  localparam logic [COL_BITS-1:0]   COL_LAST   = COL_BITS'(COLUMNS - 1);
  localparam logic [PLANE_BITS-1:0] PLANE_LAST = PLANE_BITS'(PLANES - 1);

  scan_state_t state_reg, state_next;
  logic [ROW_BITS-1:0]   row_reg, row_next;
  logic [PLANE_BITS-1:0] plane_reg, plane_next;
  logic [COL_BITS-1:0]   col_reg, col_next, rd_col;
  logic phase_reg, phase_next, pf_reg, pf_next;
  logic toggle_reg, toggle_next, ack_reg, ack_next, done_reg, done_next;
  logic timer_load, timer_done;

  logic                         rd_en_reg, rd_en_next, capture_reg;
  logic [ROW_BITS+COL_BITS-1:0] rd_addr_reg, rd_addr_next;
  logic hclk_reg, hclk_next, lat_reg, lat_next, oe_n_reg, oe_n_next;
  logic [ROW_BITS-1:0] haddr_reg, haddr_next;
  logic [2:0] top_bits, bot_bits, rgb_top_reg, rgb_bot_reg;
  logic       unused_bits;

  // Per-channel plane bit select; gi = 0/1/2 maps to R/G/B.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    localparam int OFS = (gi == 0) ? RED : ((gi == 1) ? GREEN : BLUE);
    logic [PLANES-1:0] top_planes, bot_planes;
    assign top_planes   = read_data_top[OFS +: PLANES];
    assign bot_planes   = read_data_bottom[OFS +: PLANES];
    assign top_bits[2-gi] = top_planes[plane_reg];
    assign bot_bits[2-gi] = bot_planes[plane_reg];
  end
  assign unused_bits = ^{read_data_top[31:RED+PLANES], read_data_bottom[31:RED+PLANES]};

  hub75_bcm_timer #(
    .ON_TIME   (ON_TIME),
    .PLANE_BITS(PLANE_BITS)
  ) u_bcm_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (timer_load),
    .plane  (plane_reg),
    .done   (timer_done)
  );

  always_comb begin
    state_next  = state_reg;
    row_next    = row_reg;
    plane_next  = plane_reg;
    col_next    = col_reg;
    phase_next  = phase_reg;
    pf_next     = pf_reg;
    toggle_next = toggle_reg;
    ack_next    = 1'b0;
    done_next   = 1'b0;
    timer_load  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        // A request still visible during its own ack cycle is not a new one.
        if (swap_req && !ack_reg) begin
          toggle_next = ~toggle_reg;
          ack_next    = 1'b1;
        end
        if (enable) begin
          state_next = PREFETCH;
          pf_next    = 1'b0;
        end
      end
      PREFETCH: begin
        pf_next = 1'b1;
        if (pf_reg) begin
          state_next = SHIFT;
          col_next   = '0;
          phase_next = 1'b0;
        end
      end
      SHIFT: begin
        phase_next = ~phase_reg;
        if (phase_reg) begin
          if (col_reg == COL_LAST) state_next = BLANK;
          else                     col_next   = col_reg + COL_BITS'(1);
        end
      end
      BLANK: state_next = LATCH;
      LATCH: begin
        state_next = DISPLAY;
        timer_load = 1'b1;
      end
      DISPLAY: begin
        if (timer_done) begin
          state_next = PREFETCH;
          pf_next    = 1'b0;
          if (plane_reg != PLANE_LAST) begin
            plane_next = plane_reg + PLANE_BITS'(1);
          end else begin
            plane_next = '0;
            if (row_reg != {ROW_BITS{1'b1}}) begin
              row_next = row_reg + ROW_BITS'(1);
            end else begin
              row_next   = '0;
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pin values are derived from the upcoming state so they register with no skew.
  always_comb begin
    rd_en_next = ((state_next == PREFETCH) && !pf_next) ||
                 ((state_next == SHIFT) && !phase_next && (col_next != COL_LAST));
    rd_col       = (state_next == SHIFT) ? col_next + COL_BITS'(1) : '0;
    rd_addr_next = rd_en_next ? {row_next, rd_col} : rd_addr_reg;
    hclk_next    = (state_next == SHIFT) && phase_next;
    lat_next     = (state_next == LATCH);
    oe_n_next    = (state_next != DISPLAY);
    haddr_next   = (state_next == LATCH) ? row_next : haddr_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      row_reg     <= '0;
      plane_reg   <= '0;
      col_reg     <= '0;
      phase_reg   <= 1'b0;
      pf_reg      <= 1'b0;
      toggle_reg  <= 1'b0;
      ack_reg     <= 1'b0;
      done_reg    <= 1'b0;
      rd_en_reg   <= 1'b0;
      rd_addr_reg <= '0;
      capture_reg <= 1'b0;
      hclk_reg    <= 1'b0;
      lat_reg     <= 1'b0;
      oe_n_reg    <= 1'b1;
      haddr_reg   <= '0;
      rgb_top_reg <= '0;
      rgb_bot_reg <= '0;
    end else begin
      state_reg   <= state_next;
      row_reg     <= row_next;
      plane_reg   <= plane_next;
      col_reg     <= col_next;
      phase_reg   <= phase_next;
      pf_reg      <= pf_next;
      toggle_reg  <= toggle_next;
      ack_reg     <= ack_next;
      done_reg    <= done_next;
      rd_en_reg   <= rd_en_next;
      rd_addr_reg <= rd_addr_next;
      capture_reg <= rd_en_reg;
      hclk_reg    <= hclk_next;
      lat_reg     <= lat_next;
      oe_n_reg    <= oe_n_next;
      haddr_reg   <= haddr_next;
      if (capture_reg) begin
        rgb_top_reg <= top_bits;
        rgb_bot_reg <= bot_bits;
      end
    end
  end

  assign swap_ack      = ack_reg;
  assign buffer_toggle = toggle_reg;
  assign frame_done    = done_reg;
  assign read_en       = rd_en_reg;
  assign read_addr     = rd_addr_reg;
  assign {hub75_r1, hub75_g1, hub75_b1} = rgb_top_reg;
  assign {hub75_r2, hub75_g2, hub75_b2} = rgb_bot_reg;
  assign hub75_clk     = hclk_reg;
  assign hub75_lat     = lat_reg;
  assign hub75_oe_n    = oe_n_reg;
  assign hub75_addr    = haddr_reg;

endmodule

// File: tb/tb_hub75_scanner.sv
// Bench for hub75_scanner: two-bank RAM model, a frame-level reference model
// checked every cycle, and literal checks on BCM timing, counts and resets.
module tb_hub75_scanner;

  localparam int COLUMNS   = 64;
  localparam int ROWS      = 16;
  localparam int PLANES    = 8;
  localparam int ON_TIME   = 2;
  localparam int SEG_FIXED = 2 + 2 * COLUMNS + 2;
  localparam int SEGS      = ROWS * PLANES;

  logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b0, swap_req = 1'b0;
  logic        swap_ack, buffer_toggle, frame_done, read_en;
  logic [9:0]  read_addr;
  logic [31:0] read_data_top = '0, read_data_bottom = '0;
  logic        hub75_r1, hub75_g1, hub75_b1, hub75_r2, hub75_g2, hub75_b2;
  logic        hub75_clk, hub75_lat, hub75_oe_n;
  logic [3:0]  hub75_addr;

  logic [31:0] mem_top [2][1024];
  logic [31:0] mem_bot [2][1024];

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  hub75_scanner dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .swap_req(swap_req),
    .swap_ack(swap_ack), .buffer_toggle(buffer_toggle), .frame_done(frame_done),
    .read_addr(read_addr), .read_en(read_en),
    .read_data_top(read_data_top), .read_data_bottom(read_data_bottom),
    .hub75_r1(hub75_r1), .hub75_g1(hub75_g1), .hub75_b1(hub75_b1),
    .hub75_r2(hub75_r2), .hub75_g2(hub75_g2), .hub75_b2(hub75_b2),
    .hub75_clk(hub75_clk), .hub75_lat(hub75_lat), .hub75_oe_n(hub75_oe_n),
    .hub75_addr(hub75_addr)
  );

  // Frame RAM: registered read, one cycle latency, bank chosen by buffer_toggle.
  always @(posedge clk) begin
    if (read_en) begin
      read_data_top    <= mem_top[buffer_toggle][read_addr];
      read_data_bottom <= mem_bot[buffer_toggle][read_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is SEGS segments (row-major, plane-minor), each
  // 2 prefetch + 2*COLUMNS shift + blank + latch + (ON_TIME << plane) display cycles.
  bit         m_busy, m_toggle, m_ack, m_done, m_bank;
  int         m_seg, m_k;
  logic [3:0] m_haddr;

  function automatic int seg_len(input int seg);
    return SEG_FIXED + (ON_TIME << (seg % PLANES));
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_toggle = 0; m_ack = 0; m_done = 0; m_bank = 0;
      m_seg = 0; m_k = 0; m_haddr = '0;
    end else begin
      bit accept;
      accept = 0;
      m_done = 0;
      if (!m_busy) begin
        accept = swap_req && !m_ack;
        if (accept) m_toggle = !m_toggle;
        if (enable) begin
          m_busy = 1; m_seg = 0; m_k = 0; m_bank = m_toggle;
        end
      end else if (m_k == seg_len(m_seg) - 1) begin
        if (m_seg == SEGS - 1) begin
          m_busy = 0; m_done = 1;
        end else begin
          m_seg++; m_k = 0;
        end
      end else begin
        m_k++;
      end
      m_ack = accept;
      if (m_busy && m_k == SEG_FIXED - 1) m_haddr = 4'(m_seg / PLANES);
    end
  end

  // Cycle compare against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      logic e_en, e_clk, e_lat, e_oe;
      int r, p, c, a;
      logic [31:0] pt, pb;
      e_en = 0; e_clk = 0; e_lat = 0; e_oe = 1; c = 0;
      if (m_busy) begin
        r = m_seg / PLANES;
        p = m_seg % PLANES;
        if (m_k == 0) begin
          e_en = 1;
        end else if (m_k >= 2 && m_k < 2 + 2 * COLUMNS) begin
          c = (m_k - 2) / 2;
          if (m_k % 2 == 0) e_en = (c < COLUMNS - 1);
          else e_clk = 1;
          a  = r * COLUMNS + c;
          pt = mem_top[m_bank][a];
          pb = mem_bot[m_bank][a];
          check("r1", hub75_r1, pt[16 + p]);
          check("g1", hub75_g1, pt[8 + p]);
          check("b1", hub75_b1, pt[p]);
          check("r2", hub75_r2, pb[16 + p]);
          check("g2", hub75_g2, pb[8 + p]);
          check("b2", hub75_b2, pb[p]);
        end else if (m_k == SEG_FIXED - 1) begin
          e_lat = 1;
        end else if (m_k >= SEG_FIXED) begin
          e_oe = 0;
        end
        if (e_en) check("read_addr", read_addr, r * COLUMNS + ((m_k == 0) ? 0 : c + 1));
      end
      check("read_en", read_en, e_en);
      check("hub75_clk", hub75_clk, e_clk);
      check("hub75_lat", hub75_lat, e_lat);
      check("hub75_oe_n", hub75_oe_n, e_oe);
      check("hub75_addr", hub75_addr, m_haddr);
      check("swap_ack", swap_ack, m_ack);
      check("buffer_toggle", buffer_toggle, m_toggle);
      check("frame_done", frame_done, m_done);
    end
  end

  // Per-frame statistics taken straight from the pins.
  int         st_reads, st_frames, st_rise, st_b1, st_b1r2, oe_run;
  logic [9:0] st_last_addr;
  bit         st_seen_lat;
  int         runs[$];
  int         lats[$];

  task automatic clear_stats();
    st_reads = 0; st_frames = 0; st_rise = 0; st_b1 = 0; st_b1r2 = 0;
    oe_run = 0; st_last_addr = '0; st_seen_lat = 0;
    runs.delete(); lats.delete();
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (read_en) begin
        st_reads++;
        st_last_addr = read_addr;
      end
      if (frame_done) st_frames++;
      if (!hub75_oe_n) oe_run++;
      else if (oe_run > 0) begin
        runs.push_back(oe_run);
        oe_run = 0;
      end
      if (hub75_lat) begin
        st_seen_lat = 1;
        lats.push_back(int'(hub75_addr));
      end
      if (!st_seen_lat && hub75_clk) begin
        st_rise++;
        if (hub75_b1) st_b1++;
        if (hub75_b1 && hub75_r2) st_b1r2++;
      end
    end
  end

  task automatic check_frame_stats(input string tag);
    check({tag, "_reads"}, st_reads, SEGS * COLUMNS);
    check({tag, "_last_addr"}, st_last_addr, 10'h3FF);
    check({tag, "_frames"}, st_frames, 1);
    check({tag, "_runs"}, runs.size(), SEGS);
    check({tag, "_latches"}, lats.size(), SEGS);
  endtask

  initial begin
    int cyc;
    bit found, early;
    int bcm_len [8];
    bcm_len = '{2, 4, 8, 16, 32, 64, 128, 256};
    for (int a = 0; a < 1024; a++) begin
      mem_top[0][a] = (a % 2 == 1) ? 32'h0000_0001 : 32'h0;
      mem_bot[0][a] = (a % 2 == 1) ? 32'h0001_0000 : 32'h0;
      mem_top[1][a] = $urandom;
      mem_bot[1][a] = $urandom;
    end
    clear_stats();

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_oe_n", hub75_oe_n, 1);
    check("rst_read_en", read_en, 0);
    check("rst_lat", hub75_lat, 0);
    check("rst_toggle", buffer_toggle, 0);
    check("rst_pins", {hub75_r1, hub75_g1, hub75_b1, hub75_r2, hub75_g2, hub75_b2, hub75_clk}, 0);
    #3 reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("idle_reads", st_reads, 0);
    $display("reset and idle phase done");

    // Frame 1: bank 0 pattern, swap requested at row 5.
    clear_stats();
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    found = 0;
    for (cyc = 0; cyc < 30000 && !found; cyc++) begin
      @(posedge clk); #1;
      found = m_busy && (m_seg >= 5 * PLANES);
    end
    check("wait_row5", found, 1);
    swap_req = 1'b1;
    found = 0; early = 0;
    for (cyc = 0; cyc < 30000 && !found; cyc++) begin
      @(posedge clk); #1;
      found = frame_done;
      if (!found && buffer_toggle) early = 1;
    end
    check("wait_frame1", found, 1);
    check("no_early_toggle", early, 0);
    check("toggle_at_done", buffer_toggle, 0);
    found = 0;
    for (cyc = 0; cyc < 5 && !found; cyc++) begin
      @(posedge clk); #1;
      found = swap_ack;
    end
    check("wait_ack1", found, 1);
    check("toggle_after_ack", buffer_toggle, 1);
    swap_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_frame_stats("f1");
    check("f1_rise", st_rise, 64);
    check("f1_b1", st_b1, 32);
    check("f1_b1r2", st_b1r2, 32);
    for (int p = 0; p < PLANES; p++) check("f1_bcm", runs.size() > p ? runs[p] : -1, bcm_len[p]);
    check("f1_lat0", lats.size() > 0 ? lats[0] : -1, 0);
    check("f1_lat8", lats.size() > 8 ? lats[8] : -1, 1);
    check("f1_lat_last", lats.size() > 0 ? lats[lats.size()-1] : -1, 15);
    $display("frame 1 done: reads=%0d latches=%0d", st_reads, lats.size());

    // Frame 2: fresh random bank 0, swap and enable together, enable jitter.
    for (int a = 0; a < 1024; a++) begin
      mem_top[0][a] = $urandom;
      mem_bot[0][a] = $urandom;
    end
    clear_stats();
    enable = 1'b1;
    swap_req = 1'b1;
    @(posedge clk); #1;
    check("f2_ack", swap_ack, 1);
    check("f2_toggle", buffer_toggle, 0);
    swap_req = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      enable = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    enable = 1'b0;
    found = 0;
    for (cyc = 0; cyc < 30000 && !found; cyc++) begin
      @(posedge clk); #1;
      found = frame_done;
    end
    check("wait_frame2", found, 1);
    repeat (3) @(posedge clk);
    #1;
    check_frame_stats("f2");
    check("f2_idle_oe_n", hub75_oe_n, 1);
    $display("frame 2 done: reads=%0d latches=%0d", st_reads, lats.size());

    // Asynchronous reset during DISPLAY, then mid-SHIFT at column 30.
    enable = 1'b1;
    found = 0;
    for (cyc = 0; cyc < 1000 && !found; cyc++) begin
      @(posedge clk); #1;
      found = m_busy && (m_k == SEG_FIXED);
    end
    check("wait_display", found, 1);
    check("pre_rst_oe_n", hub75_oe_n, 0);
    #1 reset_n = 1'b0;
    #1;
    check("async_oe_n", hub75_oe_n, 1);
    check("async_lat", hub75_lat, 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    found = 0;
    for (cyc = 0; cyc < 1000 && !found; cyc++) begin
      @(posedge clk); #1;
      found = m_busy && (m_k == 2 + 2 * 30 + 1);
    end
    check("wait_col30", found, 1);
    check("pre_rst_clk", hub75_clk, 1);
    #1 reset_n = 1'b0;
    #1;
    check("shift_rst_oe_n", hub75_oe_n, 1);
    check("shift_rst_lat", hub75_lat, 0);
    check("shift_rst_clk", hub75_clk, 0);
    check("shift_rst_read_en", read_en, 0);
    check("shift_rst_addr", read_addr, 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    found = 0;
    for (cyc = 0; cyc < 10 && !found; cyc++) begin
      @(posedge clk); #1;
      found = read_en;
    end
    check("restart_read", found, 1);
    check("restart_addr", read_addr, 0);
    repeat (300) @(posedge clk);
    #1 enable = 1'b0;
    $display("reset recovery phase done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
